dbg_guv_cmd_seq: RTL and testbench

DBG_GUV_CMD_SEQ -- requirements
Module: dbg_guv_cmd_seq

---
 rtl/dbg_guv_cmd_seq.sv | 142 ++++++++++++++
 tb/tb_dbg_guv_cmd_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/dbg_guv_cmd_seq.sv
// Debug governor command sequencer: queues 64-bit commands written through
// cmd_hi/cmd_lo and serializes them MSB-first as CMD_W-bit daisy-chain beats.
module dbg_guv_cmd_seq #(
  parameter int unsigned CMD_W      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          axi_aclk,
  input  logic                          axi_aresetn,
  input  logic [31:0]                   cmd_lo_value,
  input  logic [31:0]                   cmd_hi_value,
  input  logic                          cmd_hi_strobe,
  output logic [CMD_W-1:0]              cmd_TDATA,
  output logic                          cmd_TVALID,
  output logic                          cmd_TLAST,
  input  logic                          cmd_TREADY,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          drop_pulse,
  output logic [15:0]                   drop_cnt
);

  localparam int unsigned NB    = 64 / CMD_W;
  localparam int unsigned CNT_W = $clog2(NB);
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [63:0]        mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [63:0]        sh_q, sh_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               tvalid_q, tvalid_d;
  logic               tlast_q, tlast_d;
  logic               busy_q, busy_d;
  logic               drop_pulse_q, drop_pulse_d;
  logic [15:0]        drop_cnt_q, drop_cnt_d;

  logic push, drop, pop, hs, last_beat, not_empty;

  // Admission and pop decisions are made on the registered level only.
  always_comb begin
    not_empty = (level_q != '0);
    push      = cmd_hi_strobe && (level_q < LVL_W'(FIFO_DEPTH));
    drop      = cmd_hi_strobe && !push;
    hs        = tvalid_q && cmd_TREADY;
    last_beat = (cnt_q == CNT_W'(NB - 1));
  end

  always_comb begin
    state_d      = state_q;
    sh_d         = sh_q;
    cnt_d        = cnt_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (not_empty) begin
          pop      = 1'b1;
          sh_d     = mem_q[rd_ptr_q];
          cnt_d    = '0;
          tvalid_d = 1'b1;
          tlast_d  = 1'b0;
          state_d  = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (!last_beat) begin
            sh_d    = sh_q << CMD_W;
            cnt_d   = cnt_q + CNT_W'(1);
            tlast_d = (cnt_q == CNT_W'(NB - 2));
          end else if (not_empty) begin
            // Chain straight into the next command without a bubble.
            pop     = 1'b1;
            sh_d    = mem_q[rd_ptr_q];
            cnt_d   = '0;
            tlast_d = 1'b0;
          end else begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    level_d      = level_q + LVL_W'(push) - LVL_W'(pop);
    busy_d       = (level_d != '0) || (state_d != IDLE);
    drop_pulse_d = drop;
    drop_cnt_d   = (drop && (drop_cnt_q != 16'hFFFF)) ? drop_cnt_q + 16'd1 : drop_cnt_q;
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      sh_q         <= '0;
      cnt_q        <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      busy_q       <= 1'b0;
      drop_pulse_q <= 1'b0;
      drop_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      busy_q       <= busy_d;
      drop_pulse_q <= drop_pulse_d;
      drop_cnt_q   <= drop_cnt_d;
    end
  end

  // Entry storage; validity is tracked by the pointers, so no reset needed.
  always_ff @(posedge axi_aclk) begin
    if (push) mem_q[wr_ptr_q] <= {cmd_hi_value, cmd_lo_value};
  end

  assign cmd_TDATA  = sh_q[63 -: CMD_W];
  assign cmd_TVALID = tvalid_q;
  assign cmd_TLAST  = tlast_q;
  assign busy       = busy_q;
  assign fifo_level = level_q;
  assign drop_pulse = drop_pulse_q;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_dbg_guv_cmd_seq.sv
// Scoreboard bench for dbg_guv_cmd_seq with CMD_W=8, FIFO_DEPTH=4.
module tb_dbg_guv_cmd_seq;

  localparam int unsigned CMD_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned NB    = 64 / CMD_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [31:0]       lo = '0, hi = '0;
  logic              strobe = 1'b0;
  logic [CMD_W-1:0]  tdata;
  logic              tvalid, tlast;
  logic              tready = 1'b0;
  logic              busy;
  logic [2:0]        level;
  logic              dpulse;
  logic [15:0]       dcnt;

  int n_cmp = 0;
  int n_err = 0;
  int hs_cnt = 0;
  int cyc = 0;
  int first_hs = 0;
  int last_hs = 0;
  int pulses = 0;
  logic [8:0] exp_q [$];

  always #5 clk = ~clk;

  dbg_guv_cmd_seq #(.CMD_W(CMD_W), .FIFO_DEPTH(DEPTH)) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n),
    .cmd_lo_value(lo), .cmd_hi_value(hi), .cmd_hi_strobe(strobe),
    .cmd_TDATA(tdata), .cmd_TVALID(tvalid), .cmd_TLAST(tlast), .cmd_TREADY(tready),
    .busy(busy), .fifo_level(level), .drop_pulse(dpulse), .drop_cnt(dcnt)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Handshakes are observed at the negedge before the accepting posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      cyc++;
      if (dpulse) pulses++;
      if (tvalid && tready) begin
        if (exp_q.size() == 0) check("unexpected_beat", {55'd0, tlast, tdata}, 64'h1FF);
        else check("beat", {55'd0, tlast, tdata}, {55'd0, exp_q.pop_front()});
        hs_cnt++;
        if (hs_cnt == 1) first_hs = cyc;
        last_hs = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_cmd(input logic [31:0] h, input logic [31:0] l);
    logic [63:0] c;
    c = {h, l};
    for (int i = 0; i < int'(NB); i++)
      exp_q.push_back({(i == int'(NB) - 1), c[63 - 8*i -: 8]});
  endtask

  task automatic strobe_cmd(input logic [31:0] h, input logic [31:0] l);
    hi = h; lo = l; strobe = 1'b1;
    tick();
    strobe = 1'b0; hi = $urandom; lo = $urandom;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 500) begin tick(); n++; end
    check({tag, "_drain_left"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic wait_hs(input int target);
    int n;
    n = 0;
    while (hs_cnt < target && n < 200) begin tick(); n++; end
    check("wait_hs_timeout", 64'(hs_cnt >= target), 64'd1);
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst_n = 1'b0;
    exp_q.delete();
    #20 rst_n = 1'b1;
    tick();
    hs_cnt = 0; pulses = 0;
  endtask

  initial begin
    // Reset values
    #12;
    check("rst_tvalid", 64'(tvalid), 0);
    check("rst_tlast", 64'(tlast), 0);
    check("rst_tdata", 64'(tdata), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_level", 64'(level), 0);
    check("rst_dpulse", 64'(dpulse), 0);
    check("rst_dcnt", 64'(dcnt), 0);
    @(negedge clk); #2 rst_n = 1'b1;
    tick();

    // Single command, latency 2
    tready = 1'b1;
    expect_cmd(32'h01234567, 32'h89ABCDEF);
    strobe_cmd(32'h01234567, 32'h89ABCDEF);
    check("lat_n1_tvalid", 64'(tvalid), 0);
    check("lat_n1_level", 64'(level), 1);
    tick();
    check("lat_n2_tvalid", 64'(tvalid), 1);
    check("lat_n2_busy", 64'(busy), 1);
    check("first_byte", 64'(tdata), 64'h01);
    drain("single");
    check("single_beats", 64'(hs_cnt), 8);
    check("single_span", 64'(last_hs - first_hs), 7);
    check("idle_busy", 64'(busy), 0);

    // Backpressure on beat 3
    hs_cnt = 0;
    expect_cmd(32'h01234567, 32'h89ABCDEF);
    strobe_cmd(32'h01234567, 32'h89ABCDEF);
    wait_hs(3);
    tready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_tdata", 64'(tdata), 64'h67);
      check("bp_tvalid", 64'(tvalid), 1);
      check("bp_tlast", 64'(tlast), 0);
    end
    tready = 1'b1;
    drain("bp");
    check("bp_beats", 64'(hs_cnt), 8);

    // Back-to-back commands, no bubble
    hs_cnt = 0;
    expect_cmd(32'hDEADBEEF, 32'h00112233);
    expect_cmd(32'hCAFEF00D, 32'h44556677);
    strobe_cmd(32'hDEADBEEF, 32'h00112233);
    strobe_cmd(32'hCAFEF00D, 32'h44556677);
    drain("b2b");
    check("b2b_beats", 64'(hs_cnt), 16);
    check("b2b_span", 64'(last_hs - first_hs), 15);

    // Overflow: 5 accepted (1 in serializer + 4 queued), 6th dropped
    tready = 1'b0; hs_cnt = 0; pulses = 0;
    for (int i = 0; i < 6; i++) begin
      if (i < 5) expect_cmd(32'hA0000000 + 32'(i), 32'h5A5A0000 + 32'(i));
      strobe_cmd(32'hA0000000 + 32'(i), 32'h5A5A0000 + 32'(i));
    end
    tick(); tick();
    check("ovf_level", 64'(level), 4);
    check("ovf_dcnt1", 64'(dcnt), 1);
    check("ovf_pulses", 64'(pulses), 1);
    strobe_cmd(32'hBBBBBBBB, 32'hBBBBBBBB);
    tick();
    check("ovf_dcnt2", 64'(dcnt), 2);
    check("ovf_level2", 64'(level), 4);
    tready = 1'b1;
    drain("ovf");
    check("ovf_beats", 64'(hs_cnt), 40);

    // Saturation
    do_reset();
    tready = 1'b0;
    hi = 32'h11111111; lo = 32'h22222222; strobe = 1'b1;
    repeat (65540) @(posedge clk);
    #1 strobe = 1'b0;
    tick();
    check("sat_dcnt", 64'(dcnt), 64'hFFFF);
    check("sat_level", 64'(level), 4);

    // Reset mid-command
    do_reset();
    tready = 1'b1;
    check("post_rst_dcnt", 64'(dcnt), 0);
    expect_cmd(32'h01234567, 32'h89ABCDEF);
    strobe_cmd(32'hFFFFFFFF, 32'hEEEEEEEE);
    strobe_cmd(32'hDDDDDDDD, 32'hCCCCCCCC);
    exp_q.delete();
    expect_cmd(32'hFFFFFFFF, 32'hEEEEEEEE);
    wait_hs(4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_tvalid", 64'(tvalid), 0);
    check("mid_rst_busy", 64'(busy), 0);
    check("mid_rst_level", 64'(level), 0);
    check("mid_rst_tdata", 64'(tdata), 0);
    exp_q.delete();
    @(negedge clk); #2 rst_n = 1'b1;
    hs_cnt = 0;
    repeat (20) tick();
    check("after_rst_beats", 64'(hs_cnt), 0);
    check("after_rst_tvalid", 64'(tvalid), 0);

    // Fresh command after release
    expect_cmd(32'h76543210, 32'hFEDCBA98);
    strobe_cmd(32'h76543210, 32'hFEDCBA98);
    drain("fresh");
    check("fresh_beats", 64'(hs_cnt), 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
